cov_acc_sched: RTL and testbench

- Sequencer for the covariance-matrix MAC array: opens and closes accumulation windows of programmable length.
- At each window end it commands a snapshot of all MACCS_NUM accumulators into the array's shadow registers.
- It then streams the snapshot out serially over a valid/ready port toward the bus-side result buffer.
- Sits between the register map (start/stop/length) and the cov_matrix datapath, in the ADC clock domain.

---
 rtl/cov_pkg.sv | 14 +
 rtl/cov_readout_seq.sv | 103 ++++++++++
 rtl/cov_acc_sched.sv | 113 +++++++++++
 tb/tb_cov_acc_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cov_pkg.sv
// Shared types and sizing helpers for the covariance accumulation sequencer.
package cov_pkg;

   typedef enum logic [1:0] {W_IDLE, W_CLEAR, W_ACCUM, W_DUMP} win_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_PUSH} rd_state_t;

   localparam int ACCUM_WIDTH = 32;

   // Upper triangle including the diagonal of an (nch*nt)^2 covariance matrix.
   function automatic int maccs_num(input int nch, input int nt);
      return (((nch * nt) ** 2) - nch * nt) / 2 + nch * nt;
   endfunction

endpackage

// File: rtl/cov_readout_seq.sv
// Streams a shadow-register snapshot out one word at a time over a valid/ready port.
module cov_readout_seq
   import cov_pkg::*;
#(
   parameter int MACCS_NUM   = 210,
   parameter int ACCUM_WIDTH = 32,
   parameter int IDXW        = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   dump,
   output logic [IDXW-1:0]        rd_idx,
   input  logic [ACCUM_WIDTH-1:0] rd_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACCUM_WIDTH-1:0] out_data,
   output logic [IDXW-1:0]        out_idx,
   output logic                   out_last,
   output logic                   done,
   output rd_state_t              state
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MACCS_NUM - 1);

   rd_state_t              state_q, state_d;
   logic [IDXW-1:0]        idx_q, idx_d;
   logic [IDXW-1:0]        out_idx_q, out_idx_d;
   logic [ACCUM_WIDTH-1:0] out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;
   logic                   done_q, done_d;

   // Handshake: a word transfers on a clock edge where out_valid and out_ready are both
   // high; once out_valid rises, out_data/out_idx/out_last stay frozen until that edge.
   // idx only moves when entering R_ADDR, so rd_idx is stable in every other state and
   // rd_data is sampled one clock after the index is launched.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_idx_d   = out_idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      unique case (state_q)
         R_IDLE: begin
            if (dump) begin
               idx_d   = '0;
               state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            out_data_d  = rd_data;
            out_idx_d   = idx_q;
            out_last_d  = (idx_q == LAST_IDX);
            out_valid_d = 1'b1;
            state_d     = R_PUSH;
         end
         R_PUSH: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  done_d  = 1'b1;
                  state_d = R_IDLE;
               end else begin
                  idx_d   = idx_q + IDXW'(1);
                  state_d = R_ADDR;
               end
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= R_IDLE;
         idx_q       <= '0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_idx_q   <= out_idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   assign rd_idx    = idx_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign done      = done_q;
   assign state     = state_q;

endmodule

// File: rtl/cov_acc_sched.sv
// Accumulation window sequencer: clear / accumulate / dump control for the MAC array,
// with sticky overrun when a window ends before the previous snapshot has drained.
module cov_acc_sched
   import cov_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int NT          = 10,
   parameter int MACCS_NUM   = maccs_num(NCH, NT),
   parameter int ACCUM_WIDTH = cov_pkg::ACCUM_WIDTH,
   parameter int IDXW        = $clog2(MACCS_NUM)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   ce,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   continuous,
   input  logic [31:0]            acc_len,
   input  logic                   ovr_clr,
   output logic                   acc_clr,
   output logic                   acc_en,
   output logic                   acc_dump,
   output logic [IDXW-1:0]        rd_idx,
   input  logic [ACCUM_WIDTH-1:0] rd_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACCUM_WIDTH-1:0] out_data,
   output logic [IDXW-1:0]        out_idx,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);

   win_state_t win_q, win_d;
   logic [31:0] cnt_q, cnt_d;
   logic        ovr_q, ovr_d;
   rd_state_t   rd_state;
   logic        rd_idle;

   assign rd_idle = (rd_state == R_IDLE);

   // stop is tested before the terminal-count check so an abort always wins.
   always_comb begin
      win_d = win_q;
      cnt_d = cnt_q;
      unique case (win_q)
         W_IDLE: begin
            if (start) win_d = W_CLEAR;
         end
         W_CLEAR: begin
            cnt_d = (acc_len == 32'd0) ? 32'd1 : acc_len;
            win_d = stop ? W_IDLE : W_ACCUM;
         end
         W_ACCUM: begin
            if (stop) begin
               win_d = W_IDLE;
            end else if (ce) begin
               if (cnt_q == 32'd1) win_d = W_DUMP;
               else                cnt_d = cnt_q - 32'd1;
            end
         end
         W_DUMP: begin
            win_d = continuous ? W_CLEAR : W_IDLE;
         end
         default: win_d = W_IDLE;
      endcase
   end

   always_comb begin
      ovr_d = ovr_q;
      if (ovr_clr) ovr_d = 1'b0;
      if (win_q == W_DUMP && !rd_idle) ovr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         win_q <= W_IDLE;
         cnt_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         win_q <= win_d;
         cnt_q <= cnt_d;
         ovr_q <= ovr_d;
      end
   end

   assign acc_clr  = (win_q == W_CLEAR);
   assign acc_en   = (win_q == W_ACCUM) && ce;
   assign acc_dump = (win_q == W_DUMP) && rd_idle;
   assign busy     = (win_q != W_IDLE);
   assign overrun  = ovr_q;

   cov_readout_seq #(
      .MACCS_NUM   (MACCS_NUM),
      .ACCUM_WIDTH (ACCUM_WIDTH),
      .IDXW        (IDXW)
   ) u_readout (
      .clk       (clk),
      .resetn    (resetn),
      .dump      (acc_dump),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .done      (done),
      .state     (rd_state)
   );

endmodule

// File: tb/tb_cov_acc_sched.sv
// Bench for cov_acc_sched: shadow/accumulator model plus a word scoreboard.
module tb_cov_acc_sched;

   localparam int MACCS = 210;
   localparam int AW    = 32;
   localparam int IW    = 8;
   localparam int EW    = 1 + IW + AW;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          ce = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          continuous = 1'b0;
   logic          ovr_clr = 1'b0;
   logic          out_ready = 1'b0;
   logic [31:0]   acc_len = 32'd0;
   logic          acc_clr, acc_en, acc_dump, out_valid, out_last, busy, done, overrun;
   logic [IW-1:0] rd_idx, out_idx;
   logic [AW-1:0] rd_data, out_data;
   logic [AW-1:0] shadow [MACCS];

   always #5 clk = ~clk;

   assign rd_data = (int'(rd_idx) < MACCS) ? shadow[rd_idx] : '0;

   cov_acc_sched dut (
      .clk(clk), .resetn(resetn), .ce(ce), .start(start), .stop(stop),
      .continuous(continuous), .acc_len(acc_len), .ovr_clr(ovr_clr),
      .acc_clr(acc_clr), .acc_en(acc_en), .acc_dump(acc_dump), .rd_idx(rd_idx),
      .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy),
      .done(done), .overrun(overrun)
   );

   int checks = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];
   int exp_win = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- drivers for ce / out_ready ----------------
   int ce_mode = 0;   // 0: ce=1, 1: toggle
   int rdy_mode = 0;  // 0: ready=1, 1: ready=0, 2: stall 5 cycles on idx 7
   int stall_cnt = 0;

   always begin
      @(posedge clk); #1;
      ce = (ce_mode == 0) ? 1'b1 : ~ce;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'b0;
         default: begin
            if (out_valid && out_idx == 8'd7 && stall_cnt < 5) begin
               out_ready = 1'b0;
               stall_cnt++;
            end else begin
               out_ready = 1'b1;
            end
         end
      endcase
   end

   // ---------------- monitor: datapath model + scoreboard ----------------
   int cyc = 0, clr_tot = 0, en_tot = 0, dump_tot = 0, done_tot = 0;
   int en_win = 0, since_en = 0, dump_no = 0, dump_cyc = 0, done_cyc = 0;
   logic exp_done = 1'b0, hold_pend = 1'b0, prev_dump = 1'b0;
   logic [EW:0] hold_val = '0;

   always @(negedge clk) begin
      cyc++;
      if (acc_en) check_eq("en_gate", 64'(ce), 64'(1));
      if (acc_clr) begin
         clr_tot++;
         en_win = 0;
      end
      if (acc_en) begin
         en_tot++;
         en_win++;
         since_en = 0;
      end else begin
         since_en++;
      end
      if (prev_dump && !continuous) check_eq("busy_after_dump", 64'(busy), 64'(0));
      prev_dump = acc_dump;
      if (acc_dump) begin
         check_eq("dump_after_last_en", 64'(since_en), 64'(1));
         for (int i = 0; i < MACCS; i++) shadow[i] = {8'(dump_no), 16'(en_win), 8'(i)};
         dump_no++;
         dump_tot++;
         dump_cyc = cyc;
      end
      if (done || exp_done) check_eq("done", 64'(done), 64'(exp_done));
      if (done) begin
         done_tot++;
         done_cyc = cyc;
      end
      if (hold_pend) check_eq("hold", 64'({out_valid, out_last, out_idx, out_data}), 64'(hold_val));
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_valid, out_last, out_idx, out_data};
      exp_done  = 1'b0;
      if (out_valid && out_ready) begin
         check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) check_eq("word", 64'({out_last, out_idx, out_data}), 64'(exp_q.pop_front()));
         exp_done = out_last;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_window(input int len_exp);
      for (int i = 0; i < MACCS; i++)
         exp_q.push_back({(i == MACCS - 1), 8'(i), 8'(exp_win), 16'(len_exp), 8'(i)});
      exp_win++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int n;
      d0 = done_tot;
      n = 0;
      while (done_tot == d0 && n < budget) begin
         tick(1);
         n++;
      end
      check_eq("done_timeout", 64'(done_tot != d0), 64'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, e0, d0, n;

      resetn = 1'b0;
      tick(3);
      check_eq("reset_outs", 64'({acc_clr, acc_en, acc_dump, out_valid, out_last, busy, done,
                                  overrun, out_idx, rd_idx, out_data}), 64'(0));
      resetn = 1'b1;
      tick(2);

      // basic window, len 4, full-rate readout
      acc_len = 32'd4; continuous = 1'b0; ce_mode = 0; rdy_mode = 0;
      c0 = clr_tot; e0 = en_tot; d0 = dump_tot;
      push_window(4);
      pulse_start();
      wait_done(1000);
      tick(2);
      check_eq("t1_clr_cycles", 64'(clr_tot - c0), 64'(1));
      check_eq("t1_en_cycles", 64'(en_tot - e0), 64'(4));
      check_eq("t1_dumps", 64'(dump_tot - d0), 64'(1));
      check_eq("t1_dump_to_done", 64'(done_cyc - dump_cyc), 64'(421));
      check_eq("t1_busy", 64'(busy), 64'(0));
      check_eq("t1_sb_empty", 64'(exp_q.size()), 64'(0));

      // ce toggling, len 3
      ce_mode = 1; acc_len = 32'd3;
      e0 = en_tot; d0 = dump_tot;
      push_window(3);
      pulse_start();
      wait_done(1500);
      check_eq("t2_en_cycles", 64'(en_tot - e0), 64'(3));
      check_eq("t2_dumps", 64'(dump_tot - d0), 64'(1));
      ce_mode = 0;

      // backpressure on word 7
      rdy_mode = 2; acc_len = 32'd2;
      push_window(2);
      pulse_start();
      wait_done(1500);
      check_eq("t3_stall_cycles", 64'(stall_cnt), 64'(5));
      check_eq("t3_sb_empty", 64'(exp_q.size()), 64'(0));
      rdy_mode = 0;

      // continuous windows with stuck sink -> overrun
      continuous = 1'b1; acc_len = 32'd10; rdy_mode = 1;
      tick(1);
      d0 = dump_tot;
      push_window(10);
      pulse_start();
      n = 0;
      while (!overrun && n < 200) begin tick(1); n++; end
      check_eq("t4_overrun_set", 64'(overrun), 64'(1));
      check_eq("t4_single_dump", 64'(dump_tot - d0), 64'(1));
      continuous = 1'b0;
      n = 0;
      while (busy && n < 50) begin tick(1); n++; end
      check_eq("t4_idle", 64'(busy), 64'(0));
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      check_eq("t4_overrun_clr", 64'(overrun), 64'(0));
      check_eq("t4_word0_waiting", 64'({out_valid, out_idx}), 64'({1'b1, 8'd0}));
      rdy_mode = 0;
      wait_done(1000);
      check_eq("t4_dumps_total", 64'(dump_tot - d0), 64'(1));
      check_eq("t4_sb_empty", 64'(exp_q.size()), 64'(0));

      // stop at cnt==2 then a normal window
      acc_len = 32'd5;
      tick(2);
      e0 = en_tot; d0 = dump_tot;
      pulse_start();
      n = 0;
      while (en_tot - e0 < 3 && n < 20) begin tick(1); n++; end
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      tick(5);
      check_eq("t5_busy", 64'(busy), 64'(0));
      check_eq("t5_no_dump", 64'(dump_tot - d0), 64'(0));
      check_eq("t5_no_valid", 64'(out_valid), 64'(0));
      acc_len = 32'd2;
      d0 = dump_tot;
      push_window(2);
      pulse_start();
      wait_done(1000);
      check_eq("t5_restart_dump", 64'(dump_tot - d0), 64'(1));

      // zero length -> one sample, then async reset mid-readout
      acc_len = 32'd0;
      e0 = en_tot;
      push_window(1);
      pulse_start();
      n = 0;
      while (!(out_valid && out_idx >= 8'd50) && n < 400) begin tick(1); n++; end
      check_eq("t6_en_cycles", 64'(en_tot - e0), 64'(1));
      check_eq("t6_mid_readout", 64'(out_valid && out_idx >= 8'd50), 64'(1));
      #2;
      resetn = 1'b0;
      #1;
      check_eq("t6_async_reset", 64'({acc_clr, acc_en, acc_dump, out_valid, out_last, busy, done,
                                      overrun, out_idx, rd_idx, out_data}), 64'(0));
      exp_q.delete();
      d0 = done_tot;
      tick(2);
      resetn = 1'b1;
      tick(20);
      check_eq("t6_no_done", 64'(done_tot - d0), 64'(0));
      check_eq("t6_idle_after", 64'({busy, out_valid}), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
